kfps2kb_cmd_sequencer: RTL and testbench
========================================

KFPS2KB_CMD_SEQUENCER -- requirements
Module: kfps2kb_cmd_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16'd20000, giving the maximum clock cycles to wait for an ACK byte.
REQ-002 SHALL have parameter BAT_TIMEOUT, default 24'd5000000, giving the maximum clock cycles to wait for the self-test byte after reset.
REQ-003 SHALL have parameter MAX_RETRY, default 2'd2, giving the number of resends allowed per byte on 0xFE.
REQ-004 SHALL have port clock, input, 1 bit: system clock, all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port reset_req, input, 1 bit: one-cycle request to send keyboard reset 0xFF.
REQ-007 SHALL have port led_req, input, 1 bit: one-cycle request to send LED update 0xED plus an argument byte.
REQ-008 SHALL have port led_state, input, 3 bits: {caps, num, scroll}.
REQ-009 SHALL have ports tx_valid (output, 1 bit), tx_data (output, 8 bits) and tx_ready (input, 1 bit): byte handshake to the host transmitter.
REQ-010 SHALL have ports rx_valid (input, 1 bit) and rx_data (input, 8 bits): received-byte strobe and byte from the shift register.
REQ-011 SHALL have output rx_claim, 1 bit: combinational; high when the current rx byte is consumed here and must be hidden from the keycode path.
REQ-012 SHALL have outputs busy, reset_done and cmd_error, 1 bit each: busy is high when not IDLE; reset_done and cmd_error are one-cycle pulses.

Function
REQ-013 SHALL implement states IDLE, SEND_CMD, WAIT_ACK, SEND_ARG, WAIT_ARG_ACK and WAIT_BAT.
REQ-014 SHALL latch reset_req and led_req into pending_reset and pending_led flags in any state; a request arriving while its flag is already set SHALL merge into it.
REQ-015 In IDLE, SHALL serve pending_reset before pending_led, clear the served flag, and enter SEND_CMD the next cycle.
REQ-016 SHALL sample led_state into arg_reg on entry to SEND_CMD for an LED command.
REQ-017 SHALL hold tx_valid high and tx_data stable in SEND_CMD and SEND_ARG until tx_ready is high; the transfer completes on that cycle, and the next state is WAIT_ACK or WAIT_ARG_ACK respectively.
REQ-018 SHALL clear the timeout counter on entry to each WAIT state and increment it every cycle while in that state.
REQ-019 In any WAIT state, rx_valid with rx_data equal to 0xFA, 0xFE, 0xAA or 0xFC SHALL assert rx_claim; all other bytes SHALL NOT be claimed and SHALL NOT change state.
REQ-020 On 0xFA in WAIT_ACK: for LED, go to SEND_ARG; for reset, go to WAIT_BAT.
REQ-021 On 0xFA in WAIT_ARG_ACK, SHALL go to IDLE.
REQ-022 On 0xFE in WAIT_ACK or WAIT_ARG_ACK: if retry_cnt < MAX_RETRY, increment retry_cnt and resend the same byte (SEND_CMD or SEND_ARG); otherwise go to the error path.
REQ-023 retry_cnt SHALL clear whenever a byte is acknowledged.
REQ-024 In WAIT_BAT: 0xAA SHALL pulse reset_done and go to IDLE; 0xFC SHALL take the error path.
REQ-025 The timeout counter reaching ACK_TIMEOUT (or BAT_TIMEOUT in WAIT_BAT) SHALL take the error path.
REQ-026 The error path SHALL pulse cmd_error for one cycle, clear retry_cnt, go to IDLE and discard the current command; pending flags SHALL be retained.
REQ-027 If rx_valid and a timeout occur in the same cycle, the byte SHALL take priority.
REQ-028 reset_req arriving during an LED command SHALL NOT abort that command; it SHALL be served afterward.

Reset
REQ-029 On reset, SHALL set state to IDLE and clear pending flags, retry_cnt, timeout counter and arg_reg.
REQ-030 On reset, tx_valid, tx_data, busy, reset_done and cmd_error SHALL be 0; reset mid-transfer SHALL drop tx_valid immediately.

Configuration
REQ-031 With macro KFPS2KB_AUTO_LED_RESTORE_EN defined, a reset_done SHALL also set pending_led, and the next LED command SHALL send the current led_state.
REQ-032 Without KFPS2KB_AUTO_LED_RESTORE_EN, reset_done SHALL have no effect on pending_led.

Verification
REQ-033 led_req with led_state=3'b101, ACKs 0xFA, 0xFA -> tx bytes 0xED then 0x05, rx_claim on both ACKs, busy low after the second ACK.
REQ-034 reset_req and led_req in the same cycle -> 0xFF sent first; then 0xFA, 0xAA -> reset_done pulse; then 0xED sent.
REQ-035 led_req answered 0xFE three times -> 0xED sent 3 times total, then cmd_error pulse, state IDLE.
REQ-036 led_req with no response -> cmd_error exactly ACK_TIMEOUT cycles after entering WAIT_ACK.
REQ-037 In WAIT_ACK, rx 0x1C (a make code) -> rx_claim low, state unchanged; then 0xFA -> SEND_ARG.
REQ-038 reset asserted while tx_valid is high -> tx_valid low the same cycle; after release, busy=0 and no pending requests.

Source files
------------

// File: rtl/kfps2kb_cmd_sequencer.sv
// PS/2 keyboard command sequencer: sends reset (0xFF) and LED (0xED + arg), tracks ACK/resend/BAT replies.
// Optional: KFPS2KB_AUTO_LED_RESTORE_EN re-queues an LED update after a successful keyboard self-test.
module kfps2kb_cmd_sequencer #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd20000,
    parameter logic [23:0] BAT_TIMEOUT = 24'd5000000,
    parameter logic [1:0]  MAX_RETRY   = 2'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reset_req,
    input  logic       led_req,
    input  logic [2:0] led_state,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_claim,
    output logic       busy,
    output logic       reset_done,
    output logic       cmd_error,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SEND_CMD     = 3'd1,
        WAIT_ACK     = 3'd2,
        SEND_ARG     = 3'd3,
        WAIT_ARG_ACK = 3'd4,
        WAIT_BAT     = 3'd5
    } state_t;

    localparam logic [7:0]  B_ACK    = 8'hFA;
    localparam logic [7:0]  B_RESEND = 8'hFE;
    localparam logic [7:0]  B_BAT_OK = 8'hAA;
    localparam logic [7:0]  B_BAT_NG = 8'hFC;
    localparam logic [23:0] ACK_LIM  = {8'd0, ACK_TIMEOUT};
    localparam logic [23:0] BAT_LIM  = BAT_TIMEOUT;

    state_t      r_state;
    logic        r_pending_reset;
    logic        r_pending_led;
    logic        r_is_led;
    logic [7:0]  r_arg;
    logic [1:0]  r_retry;
    logic [23:0] r_timer;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_reset_done;
    logic        r_cmd_error;

    logic w_in_ack_wait;
    logic w_in_wait;
    logic w_known_byte;
    logic w_timeout;
    logic w_error;

    assign w_in_ack_wait = (r_state == WAIT_ACK) || (r_state == WAIT_ARG_ACK);
    assign w_in_wait     = w_in_ack_wait || (r_state == WAIT_BAT);
    assign w_known_byte  = (rx_data == B_ACK) || (rx_data == B_RESEND) ||
                           (rx_data == B_BAT_OK) || (rx_data == B_BAT_NG);

    // Expires on the cycle the counter would reach the limit; any received byte that cycle wins instead.
    assign w_timeout = (r_state == WAIT_BAT) ? (r_timer >= BAT_LIM - 24'd1)
                                             : (r_timer >= ACK_LIM - 24'd1);

    assign w_error = (w_in_ack_wait && rx_valid && (rx_data == B_RESEND) && (r_retry >= MAX_RETRY)) ||
                     ((r_state == WAIT_BAT) && rx_valid && (rx_data == B_BAT_NG)) ||
                     (w_in_wait && !rx_valid && w_timeout);

    assign rx_claim    = rx_valid && w_in_wait && w_known_byte;
    assign busy        = (r_state != IDLE);
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign reset_done  = r_reset_done;
    assign cmd_error   = r_cmd_error;
    assign o_dbg_state = r_state;

    // Transmit handshake: tx_valid/tx_data stay fixed until a cycle with tx_ready high; that cycle transfers the byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_pending_reset <= 1'b0;
            r_pending_led   <= 1'b0;
            r_is_led        <= 1'b0;
            r_arg           <= 8'd0;
            r_retry         <= 2'd0;
            r_timer         <= 24'd0;
            r_tx_valid      <= 1'b0;
            r_tx_data       <= 8'd0;
            r_reset_done    <= 1'b0;
            r_cmd_error     <= 1'b0;
        end else begin
            r_reset_done <= 1'b0;
            r_cmd_error  <= 1'b0;
            if (w_error) begin
                r_cmd_error <= 1'b1;
                r_retry     <= 2'd0;
                r_tx_valid  <= 1'b0;
                r_state     <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_pending_reset) begin
                            r_pending_reset <= 1'b0;
                            r_is_led        <= 1'b0;
                            r_tx_data       <= 8'hFF;
                            r_tx_valid      <= 1'b1;
                            r_state         <= SEND_CMD;
                        end else if (r_pending_led) begin
                            r_pending_led <= 1'b0;
                            r_is_led      <= 1'b1;
                            r_arg         <= {5'd0, led_state};
                            r_tx_data     <= 8'hED;
                            r_tx_valid    <= 1'b1;
                            r_state       <= SEND_CMD;
                        end
                    end
                    SEND_CMD, SEND_ARG: begin
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_timer    <= 24'd0;
                            r_state    <= (r_state == SEND_CMD) ? WAIT_ACK : WAIT_ARG_ACK;
                        end
                    end
                    WAIT_ACK, WAIT_ARG_ACK: begin
                        r_timer <= r_timer + 24'd1;
                        if (rx_valid && (rx_data == B_ACK)) begin
                            r_retry <= 2'd0;
                            if (r_state == WAIT_ARG_ACK) begin
                                r_state <= IDLE;
                            end else if (r_is_led) begin
                                r_tx_data  <= r_arg;
                                r_tx_valid <= 1'b1;
                                r_state    <= SEND_ARG;
                            end else begin
                                r_timer <= 24'd0;
                                r_state <= WAIT_BAT;
                            end
                        end else if (rx_valid && (rx_data == B_RESEND)) begin
                            // tx_data still holds the byte being resent
                            r_retry    <= r_retry + 2'd1;
                            r_tx_valid <= 1'b1;
                            r_state    <= (r_state == WAIT_ACK) ? SEND_CMD : SEND_ARG;
                        end
                    end
                    WAIT_BAT: begin
                        r_timer <= r_timer + 24'd1;
                        if (rx_valid && (rx_data == B_BAT_OK)) begin
                            r_reset_done <= 1'b1;
                            r_state      <= IDLE;
`ifdef KFPS2KB_AUTO_LED_RESTORE_EN
                            r_pending_led <= 1'b1;
`else
                            r_pending_led <= r_pending_led;
`endif
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
            // New requests are recorded last so they win over a same-cycle service clear.
            if (reset_req) r_pending_reset <= 1'b1;
            if (led_req)   r_pending_led   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_kfps2kb_cmd_sequencer.sv
// Self-checking bench for kfps2kb_cmd_sequencer: directed scenarios plus randomized command/reply sequences.
module tb_kfps2kb_cmd_sequencer;

  localparam logic [15:0] ACK_TO = 16'd40;
  localparam logic [23:0] BAT_TO = 24'd60;
  localparam logic [1:0]  MR     = 2'd2;

  logic       clock = 1'b0;
  logic       reset;
  logic       reset_req, led_req;
  logic [2:0] led_state;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_claim, busy, reset_done, cmd_error;
  logic [2:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rsp_q[$];

  kfps2kb_cmd_sequencer #(
    .ACK_TIMEOUT(ACK_TO),
    .BAT_TIMEOUT(BAT_TO),
    .MAX_RETRY(MR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .reset_req(reset_req),
    .led_req(led_req),
    .led_state(led_state),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_claim(rx_claim),
    .busy(busy),
    .reset_done(reset_done),
    .cmd_error(cmd_error),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic pulse_led(input logic [2:0] ls);
    led_state = ls;
    led_req = 1'b1;
    tick();
    led_req = 1'b0;
  endtask

  task automatic pulse_reset_req();
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] b, input string tag);
    int n = 0;
    int stall;
    while (tx_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " tx_valid"}, {31'd0, tx_valid}, 32'd1);
    if (tx_valid !== 1'b1) return;
    chk({tag, " tx_data"}, {24'd0, tx_data}, {24'd0, b});
    stall = $urandom_range(0, 2);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, " tx_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, b});
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk({tag, " tx_done"}, {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic exp_claim, input string tag);
    rx_valid = 1'b1;
    rx_data = b;
    #1;
    chk({tag, " rx_claim"}, {31'd0, rx_claim}, {31'd0, exp_claim});
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] junk_byte();
    logic [7:0] j;
    do j = 8'($urandom_range(0, 255));
    while (j == 8'hFA || j == 8'hFE || j == 8'hAA || j == 8'hFC);
    return j;
  endfunction

  // reference model: the i-th send of a byte is NAKed while i < naks; more than MR NAKs is an error
  task automatic plan_byte(input logic [7:0] b, input int naks, output bit failed);
    int sends;
    sends = (naks > int'(MR)) ? int'(MR) + 1 : naks + 1;
    for (int i = 0; i < sends; i++) begin
      exp_q.push_back(b);
      rsp_q.push_back((i < naks) ? 8'hFE : 8'hFA);
    end
    failed = (naks > int'(MR));
  endtask

  task automatic run_plan(input string tag);
    logic [7:0] b, r;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      r = rsp_q.pop_front();
      expect_tx(b, tag);
      if ($urandom_range(0, 3) == 0) begin
        send_rx(junk_byte(), 1'b0, {tag, " junk"});
        chk({tag, " junk busy/tx"}, {30'd0, busy, tx_valid}, {30'd0, 1'b1, 1'b0});
      end
      send_rx(r, 1'b1, tag);
      if (exp_q.size() > 0) chk({tag, " mid err"}, {31'd0, cmd_error}, 32'd0);
    end
  endtask

  initial begin
    bit f1, f2;
    logic [2:0] ls;
    logic [7:0] bat;

    reset = 1'b1; reset_req = 0; led_req = 0; led_state = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    tick(); tick();
    chk("reset outputs", {19'd0, tx_valid, tx_data, busy, reset_done, cmd_error, rx_claim},
        32'd0);
    reset = 1'b0;
    tick();
    chk("post-reset idle", {30'd0, busy, tx_valid}, 32'd0);

    // LED update, both bytes acknowledged
    pulse_led(3'b101);
    expect_tx(8'hED, "led cmd");
    send_rx(8'hFA, 1'b1, "led ack1");
    expect_tx(8'h05, "led arg");
    send_rx(8'hFA, 1'b1, "led ack2");
    chk("led busy after ack", {31'd0, busy}, 32'd0);

    // simultaneous requests: reset served first, LED afterwards
    led_state = 3'b011;
    reset_req = 1'b1; led_req = 1'b1;
    tick();
    reset_req = 1'b0; led_req = 1'b0;
    expect_tx(8'hFF, "both rst");
    send_rx(8'hFA, 1'b1, "both rst ack");
    chk("both in bat", {30'd0, busy, reset_done}, {30'd0, 1'b1, 1'b0});
    send_rx(8'hAA, 1'b1, "both bat");
    chk("both reset_done", {31'd0, reset_done}, 32'd1);
    tick();
    chk("reset_done pulse", {31'd0, reset_done}, 32'd0);
    expect_tx(8'hED, "both led");
    send_rx(8'hFA, 1'b1, "both led ack");
    expect_tx(8'h03, "both led arg");
    send_rx(8'hFA, 1'b1, "both led arg ack");
    chk("both idle", {31'd0, busy}, 32'd0);

    // three resends requested: command sent three times, then error
    pulse_led(3'b001);
    for (int i = 0; i < 3; i++) begin
      expect_tx(8'hED, "nak cmd");
      send_rx(8'hFE, 1'b1, "nak");
    end
    chk("nak error", {30'd0, cmd_error, busy}, {30'd0, 1'b1, 1'b0});
    tick();
    chk("nak error pulse", {30'd0, cmd_error, tx_valid}, 32'd0);

    // no reply: error exactly ACK_TO cycles after entering WAIT_ACK
    pulse_led(3'b110);
    expect_tx(8'hED, "to cmd");
    for (int c = 1; c <= int'(ACK_TO); c++) begin
      tick();
      chk("ack timeout", {31'd0, cmd_error}, (c == int'(ACK_TO)) ? 32'd1 : 32'd0);
    end
    chk("ack timeout idle", {31'd0, busy}, 32'd0);

    // unrelated byte is ignored, then ACK proceeds
    pulse_led(3'b010);
    expect_tx(8'hED, "mk cmd");
    send_rx(8'h1C, 1'b0, "make code");
    chk("make code no change", {30'd0, busy, tx_valid}, {30'd0, 1'b1, 1'b0});
    send_rx(8'hFA, 1'b1, "mk ack");
    chk("mk send_arg", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h02});
    expect_tx(8'h02, "mk arg");
    send_rx(8'hFA, 1'b1, "mk arg ack");

    // byte arriving on the timeout cycle wins
    pulse_led(3'b100);
    expect_tx(8'hED, "prio cmd");
    for (int i = 0; i < int'(ACK_TO) - 1; i++) tick();
    chk("prio before", {31'd0, cmd_error}, 32'd0);
    send_rx(8'hFA, 1'b1, "prio ack");
    chk("prio no error", {31'd0, cmd_error}, 32'd0);
    expect_tx(8'h04, "prio arg");
    send_rx(8'hFA, 1'b1, "prio arg ack");
    chk("prio idle", {31'd0, busy}, 32'd0);

    // self-test timeout
    pulse_reset_req();
    expect_tx(8'hFF, "bat cmd");
    send_rx(8'hFA, 1'b1, "bat ack");
    for (int c = 1; c <= int'(BAT_TO); c++) begin
      tick();
      if (c >= int'(BAT_TO) - 1)
        chk("bat timeout", {31'd0, cmd_error}, (c == int'(BAT_TO)) ? 32'd1 : 32'd0);
    end
    chk("bat timeout idle", {31'd0, busy}, 32'd0);

    // reset request during LED command waits its turn
    pulse_led(3'b111);
    expect_tx(8'hED, "defer cmd");
    pulse_reset_req();
    send_rx(8'hFA, 1'b1, "defer ack");
    expect_tx(8'h07, "defer arg");
    send_rx(8'hFA, 1'b1, "defer arg ack");
    expect_tx(8'hFF, "defer rst");
    send_rx(8'hFA, 1'b1, "defer rst ack");
    send_rx(8'hAA, 1'b1, "defer bat");
    chk("defer done", {30'd0, reset_done, cmd_error}, {30'd0, 1'b1, 1'b0});
    tick();
    chk("defer idle", {31'd0, busy}, 32'd0);

    // async reset mid-transfer drops tx_valid at once and forgets pending work
    pulse_led(3'b101);
    pulse_reset_req();
    for (int n = 0; n < 10 && tx_valid !== 1'b1; n++) tick();
    chk("pre-reset tx_valid", {31'd0, tx_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset tx_valid", {30'd0, tx_valid, busy}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("after reset quiet", {30'd0, busy, tx_valid}, 32'd0);
    end

    // randomized commands and replies against the model
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        ls = 3'($urandom_range(0, 7));
        plan_byte(8'hED, $urandom_range(0, 3), f1);
        f2 = 1'b0;
        if (!f1) plan_byte({5'd0, ls}, $urandom_range(0, 3), f2);
        pulse_led(ls);
        run_plan("rnd led");
        chk("rnd led end", {30'd0, cmd_error, busy}, {30'd0, f1 | f2, 1'b0});
      end else begin
        plan_byte(8'hFF, $urandom_range(0, 3), f1);
        pulse_reset_req();
        run_plan("rnd rst");
        if (f1) begin
          chk("rnd rst nak end", {30'd0, cmd_error, busy}, {30'd0, 1'b1, 1'b0});
        end else begin
          chk("rnd rst in bat", {30'd0, cmd_error, busy}, {30'd0, 1'b0, 1'b1});
          bat = ($urandom_range(0, 3) == 0) ? 8'hFC : 8'hAA;
          if ($urandom_range(0, 2) == 0) send_rx(junk_byte(), 1'b0, "rnd bat junk");
          send_rx(bat, 1'b1, "rnd bat");
          chk("rnd bat result", {29'd0, reset_done, cmd_error, busy},
              {29'd0, bat == 8'hAA, bat == 8'hFC, 1'b0});
        end
      end
      tick();
      chk("rnd idle", {30'd0, busy, tx_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
